// File: rtl/lif_pkg.sv
// Shared types and default sizing for the LIF neuron spike readout path.
package lif_pkg;

  localparam int TS_W_DEF   = 16;
  localparam int V_W_DEF    = 8;
  localparam int DEPTH_DEF  = 8;
  localparam int DROP_W_DEF = 8;

  typedef struct packed {
    logic [TS_W_DEF-1:0] ts;
    logic [V_W_DEF-1:0]  v;
  } spike_evt_t;

endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous show-ahead FIFO of spike events with a registered head entry.
module spike_event_fifo
  import lif_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  spike_evt_t  din,
  input  logic        pop,
  output spike_evt_t  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] next_rd_idx;
  logic          do_push;
  logic          do_pop;
  spike_evt_t    mem [DEPTH];

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop      = pop && !empty;
  assign do_push     = push && (!full || do_pop);
  assign next_rd_idx = rd_ptr[AW-1:0] + 1'b1;

  // NOTE: storage is not reset; only pointers and the head register need a known state.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // Head refills from the incoming event when it becomes the only entry.
      if (do_push && (empty || (do_pop && level == (AW+1)'(1))))
        dout <= din;
      else if (do_pop && level > (AW+1)'(1))
        dout <= mem[next_rd_idx];
    end
  end

endmodule

// File: rtl/spike_event_logger.sv
// Timestamps rising edges of a neuron axon, buffers them and counts drops.
module spike_event_logger
  import lif_pkg::*;
#(
  parameter int TS_W   = TS_W_DEF,
  parameter int V_W    = V_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DROP_W = DROP_W_DEF,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axon,
  input  logic [V_W-1:0]    V,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [TS_W-1:0]   evt_ts,
  output logic [V_W-1:0]    evt_v,
  output logic [LW-1:0]     level,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  logic [TS_W-1:0] ts_cnt;
  logic            axon_q;
  logic            spike;
  logic            pop;
  logic            full;
  logic            empty;
  logic            drop;
  spike_evt_t      din;
  spike_evt_t      head;

  assign spike     = axon && !axon_q;
  assign pop       = evt_valid && evt_ready;
  assign drop      = spike && full && !pop;
  assign evt_valid = !empty;
  assign evt_ts    = head.ts;
  assign evt_v     = head.v;

  always_comb begin
    din    = '0;
    din.ts = ts_cnt;
    din.v  = V;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ts_cnt     <= '0;
      axon_q     <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      axon_q <= axon;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
    end
  end

  spike_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (spike),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_spike_event_logger.sv
// Directed self-checking bench for spike_event_logger.
module tb_spike_event_logger;

  logic        clk;
  logic        rst;
  logic        axon;
  logic [7:0]  V;
  logic        evt_valid;
  logic        evt_ready;
  logic [15:0] evt_ts;
  logic [7:0]  evt_v;
  logic [3:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_ts   = 0;

  spike_event_logger dut (
    .clk        (clk),
    .rst        (rst),
    .axon       (axon),
    .V          (V),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_ts     (evt_ts),
    .evt_v      (evt_v),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; cur_ts tracks the value the timestamp counter holds afterwards.
  task automatic tick();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    cur_ts = r ? ((cur_ts + 1) & 16'hFFFF) : 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic advance_to(input int t);
    while (cur_ts != t) tick();
  endtask

  task automatic test_reset();
    axon = 1'b0; V = '0; evt_ready = 1'b0;
    do_reset();
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", evt_valid); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_checks++; if ({overflow, drop_count} !== 9'd0) begin n_fail++; $display("FAIL reset_drop got ovf=%0b cnt=%0d want 0/0", overflow, drop_count); end
    n_checks++; if ({evt_ts, evt_v} !== 24'd0) begin n_fail++; $display("FAIL reset_head got ts=%0d v=%0h want 0/0", evt_ts, evt_v); end
  endtask

  task automatic test_single_pulse();
    do_reset();
    advance_to(10);
    axon = 1'b1; V = 8'h80;
    tick();
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL pulse_valid got %0b want 1", evt_valid); end
    n_checks++; if (evt_ts !== 16'd10) begin n_fail++; $display("FAIL pulse_ts got %0d want 10", evt_ts); end
    n_checks++; if (evt_v !== 8'h80) begin n_fail++; $display("FAIL pulse_v got %0h want 80", evt_v); end
    n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL pulse_level got %0d want 1", level); end
    axon = 1'b0; V = 8'h00; evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL pulse_pop_valid got %0b want 0", evt_valid); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL pulse_pop_level got %0d want 0", level); end
  endtask

  task automatic test_held_high();
    do_reset();
    advance_to(3);
    axon = 1'b1; V = 8'h11;
    for (int i = 0; i < 20; i++) tick();
    axon = 1'b0;
    tick();
    n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL held_level got %0d want 1", level); end
    n_checks++; if (evt_ts !== 16'd3) begin n_fail++; $display("FAIL held_ts got %0d want 3", evt_ts); end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL held_drain got valid=%0b want 0", evt_valid); end
  endtask

  task automatic test_overflow_drain();
    do_reset();
    while (cur_ts <= 20) begin
      axon = (cur_ts >= 2) && (cur_ts % 2 == 0);
      V = 8'(cur_ts);
      tick();
    end
    axon = 1'b0;
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level got %0d want 8", level); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    n_checks++; if (drop_count !== 8'd2) begin n_fail++; $display("FAIL ovf_drops got %0d want 2", drop_count); end
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (evt_valid !== 1'b1 || evt_ts !== 16'(2 + 2*i) || evt_v !== 8'(2 + 2*i)) begin
        n_fail++;
        $display("FAIL drain_beat%0d got valid=%0b ts=%0d v=%0d want 1/%0d/%0d", i, evt_valid, evt_ts, evt_v, 2+2*i, 2+2*i);
      end
      tick();
    end
    evt_ready = 1'b0;
    n_checks++; if (evt_valid !== 1'b0 || level !== 4'd0) begin n_fail++; $display("FAIL drain_end got valid=%0b level=%0d want 0/0", evt_valid, level); end
    n_checks++; if (overflow !== 1'b1 || drop_count !== 8'd2) begin n_fail++; $display("FAIL ovf_sticky got ovf=%0b cnt=%0d want 1/2", overflow, drop_count); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    while (cur_ts <= 17) begin
      axon = (cur_ts >= 2) && (cur_ts % 2 == 0);
      tick();
    end
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL full_pre_level got %0d want 8", level); end
    axon = 1'b1; evt_ready = 1'b1;
    tick();
    axon = 1'b0;
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL full_pp_level got %0d want 8", level); end
    n_checks++; if (drop_count !== 8'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL full_pp_drop got ovf=%0b cnt=%0d want 0/0", overflow, drop_count); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (evt_valid !== 1'b1 || evt_ts !== 16'(4 + 2*i)) begin
        n_fail++;
        $display("FAIL full_drain%0d got valid=%0b ts=%0d want 1/%0d", i, evt_valid, evt_ts, 4+2*i);
      end
      tick();
    end
    evt_ready = 1'b0;
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain_end got %0b want 0", evt_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    advance_to(65535);
    axon = 1'b1; V = 8'hA5;
    tick();
    axon = 1'b0;
    n_checks++; if (evt_ts !== 16'hFFFF || evt_v !== 8'hA5) begin n_fail++; $display("FAIL wrap_first got ts=%0h v=%0h want ffff/a5", evt_ts, evt_v); end
    tick();
    axon = 1'b1; V = 8'h5A;
    tick();
    axon = 1'b0;
    n_checks++; if (level !== 4'd2) begin n_fail++; $display("FAIL wrap_level got %0d want 2", level); end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_checks++; if (evt_ts !== 16'h0001 || evt_v !== 8'h5A) begin n_fail++; $display("FAIL wrap_second got ts=%0h v=%0h want 0001/5a", evt_ts, evt_v); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 540; i++) begin
      axon = ~axon;
      tick();
    end
    axon = 1'b0;
    n_checks++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_drops got %0d want 255", drop_count); end
    n_checks++; if (level !== 4'd8 || overflow !== 1'b1) begin n_fail++; $display("FAIL sat_state got level=%0d ovf=%0b want 8/1", level, overflow); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      axon = ~axon;
      tick();
    end
    axon = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    evt_ready = 1'b0;
    n_checks++; if (level !== 4'd5 || overflow !== 1'b1) begin n_fail++; $display("FAIL mid_pre got level=%0d ovf=%0b want 5/1", level, overflow); end
    // Reset with axon already high and a pop requested: reset must win.
    rst = 1'b0; axon = 1'b1; evt_ready = 1'b1;
    tick();
    n_checks++; if (level !== 4'd0 || evt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst got level=%0d valid=%0b want 0/0", level, evt_valid); end
    n_checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL mid_rst_drop got ovf=%0b cnt=%0d want 0/0", overflow, drop_count); end
    rst = 1'b1; evt_ready = 1'b0; V = 8'h42;
    tick();
    axon = 1'b0;
    n_checks++; if (evt_valid !== 1'b1 || evt_ts !== 16'd0 || evt_v !== 8'h42) begin n_fail++; $display("FAIL mid_restart got valid=%0b ts=%0d v=%0h want 1/0/42", evt_valid, evt_ts, evt_v); end
  endtask

  initial begin
    rst = 1'b0; axon = 1'b0; V = '0; evt_ready = 1'b0;
    test_reset();
    test_single_pulse();
    test_held_high();
    test_overflow_drain();
    test_full_push_pop();
    test_wrap();
    test_saturate();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
